dcache_2way: RTL

Two-way set-associative, write-back, write-allocate data cache with a parametrised line width and set count. It sits between the CPU memory stage (p1_* port) and the line-wide data memory (mem_* port). It replaces the direct-mapped data cache, adds per-set LRU replacement and byte-enabled stores, and keeps tag and data storage as internal register arrays.

---
 rtl/dcache_2way.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_2way.sv
`timescale 1ns/1ps
// Two-way set-associative, write-back, write-allocate data cache with per-set LRU and byte-enabled stores.
// Define DCACHE_PERF_CNT_EN to add the hit_cnt_o / miss_cnt_o performance counters.
module dcache_2way #(
  parameter int LINE_W   = 256,
  parameter int SET_BITS = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [31:0]       mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [31:0]       p1_data_i,
  input  logic [3:0]        p1_be_i,
  input  logic [31:0]       p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [1:0]        dbg_state_o
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = 32 - SET_BITS - OFF_W;

  typedef enum logic [1:0] {IDLE, MISS, WRITEBACK, READMISS} state_e;

  state_e                     state_q, state_d;
  logic                       victim_q, victim_d;
  logic                       enable_q, enable_d;
  logic                       write_q, write_d;
  logic [SETS-1:0][1:0]       valid_q, dirty_q;
  logic [SETS-1:0]            lru_q;
  logic [TAG_W-1:0]           tag_q  [SETS][2];
  logic [LINE_W-1:0]          data_q [SETS][2];

  logic [SET_BITS-1:0]        idx;
  logic [TAG_W-1:0]           tag;
  logic [OFF_W+2:0]           bit_off;
  logic                       req, hit0, hit1, hit, hit_way;
  logic                       idle_hit, refill, victim_sel, victim_dirty;
  logic [31:0]                hit_word, merged_word;
  logic                       unused_addr;

  assign idx         = p1_addr_i[OFF_W+SET_BITS-1:OFF_W];
  assign tag         = p1_addr_i[31:OFF_W+SET_BITS];
  assign bit_off     = {p1_addr_i[OFF_W-1:2], 5'b0};
  assign unused_addr = ^p1_addr_i[1:0];

  assign hit0    = valid_q[idx][0] && (tag_q[idx][0] == tag);
  assign hit1    = valid_q[idx][1] && (tag_q[idx][1] == tag);
  assign hit     = hit0 | hit1;
  // Way 0 takes priority if both ways ever match.
  assign hit_way = ~hit0;

  assign req        = p1_MemRead_i | p1_MemWrite_i;
  assign idle_hit   = req && hit && (state_q == IDLE);
  assign refill     = (state_q == READMISS) && mem_ack_i;
  assign hit_word   = data_q[idx][hit_way][bit_off +: 32];
  assign p1_data_o  = hit ? hit_word : 32'd0;
  assign p1_stall_o = req & ~idle_hit;

  always_comb begin
    merged_word = hit_word;
    for (int b = 0; b < 4; b++) begin
      if (p1_be_i[b]) merged_word[8*b +: 8] = p1_data_i[8*b +: 8];
    end
  end

  always_comb begin
    victim_sel = lru_q[idx];
    if (!valid_q[idx][0])      victim_sel = 1'b0;
    else if (!valid_q[idx][1]) victim_sel = 1'b1;
    victim_dirty = valid_q[idx][victim_sel] && dirty_q[idx][victim_sel];
  end

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    enable_d = enable_q;
    write_d  = write_q;
    unique case (state_q)
      IDLE: begin
        if (req && !hit) state_d = MISS;
      end
      MISS: begin
        victim_d = victim_sel;
        enable_d = 1'b1;
        if (victim_dirty) begin
          write_d = 1'b1;
          state_d = WRITEBACK;
        end else begin
          write_d = 1'b0;
          state_d = READMISS;
        end
      end
      WRITEBACK: begin
        // Enable stays high so the refill read follows the writeback directly.
        if (mem_ack_i) begin
          write_d = 1'b0;
          state_d = READMISS;
        end
      end
      READMISS: begin
        if (mem_ack_i) begin
          enable_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      enable_q <= 1'b0;
      write_q  <= 1'b0;
      valid_q  <= '0;
      dirty_q  <= '0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      enable_q <= enable_d;
      write_q  <= write_d;
      if (refill) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
      if (idle_hit) begin
        lru_q[idx] <= ~hit_way;
        if (p1_MemWrite_i) dirty_q[idx][hit_way] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (refill) begin
      data_q[idx][victim_q] <= mem_data_i;
      tag_q[idx][victim_q]  <= tag;
    end else if (idle_hit && p1_MemWrite_i) begin
      data_q[idx][hit_way][bit_off +: 32] <= merged_word;
    end
  end

  assign mem_enable_o = enable_q;
  assign mem_write_o  = write_q;
  assign mem_data_o   = data_q[idx][victim_q];
  assign mem_addr_o   = (state_q == WRITEBACK) ?
                        {tag_q[idx][victim_q], idx, {OFF_W{1'b0}}} :
                        {tag, idx, {OFF_W{1'b0}}};
  assign dbg_state_o  = state_q;

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if (idle_hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      if ((state_q == IDLE) && req && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif
endmodule
